// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier controller.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Iteration counter width: holds 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/cla_add.sv
// WIDTH-bit carry-lookahead adder: 4-bit lookahead groups, group carries rippled.
module cla_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned NumGrp = (WIDTH + 3) / 4;
  localparam int unsigned PadW   = NumGrp * 4;

  logic [PadW-1:0] w_a;
  logic [PadW-1:0] w_b;
  logic [PadW-1:0] w_g;
  logic [PadW-1:0] w_p;
  logic [PadW:0]   w_c;

  assign w_a = PadW'(a);
  assign w_b = PadW'(b);
  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Each group's internal carries look ahead from the group carry-in only.
  always_comb begin
    w_c    = '0;
    w_c[0] = ci;
    for (int k = 0; k < NumGrp; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
  end

  assign sum = w_p[WIDTH-1:0] ^ w_c[WIDTH-1:0];
  assign co  = w_c[WIDTH];

endmodule

// File: rtl/mul_ctrl.sv
// Sequential shift-add unsigned multiplier, one iteration per clock.
// Optional MUL_ZERO_SKIP_EN: zero operands complete in a single edge.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               op_done
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  mul_state_t         r_state;
  mul_state_t         w_state_d;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CntW-1:0]    r_count;

  logic [WIDTH-1:0]   w_sum;
  logic               w_co;
  logic [2*WIDTH-1:0] w_acc_step;
  logic               w_last;
  logic               w_zero_op;

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  cla_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .a  (r_acc[2*WIDTH-1:WIDTH]),
    .b  (r_mcand),
    .ci (1'b0),
    .sum(w_sum),
    .co (w_co)
  );

  // Adder carry lands in the top bit so a full-scale square stays exact.
  assign w_acc_step = r_acc[0] ? {w_co, w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};
  assign w_last     = (r_count == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (op_clear)      w_state_d = IDLE;
        else if (op_start) w_state_d = w_zero_op ? DONE : EXEC;
      end
      EXEC: begin
        if (op_clear)    w_state_d = IDLE;
        else if (w_last) w_state_d = DONE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == EXEC);
    op_done = (r_state == DONE);
    result  = r_acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_count <= '0;
    end else if (op_clear) begin
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (op_start) begin
            r_mcand <= multiplicand;
            r_acc   <= w_zero_op ? '0 : {{WIDTH{1'b0}}, multiplier};
            r_count <= '0;
          end
        end
        EXEC: begin
          r_acc   <= w_acc_step;
          r_count <= r_count + CntW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Randomised self-checking bench for mul_ctrl against an arithmetic product model.
module tb_mul_ctrl;

  localparam int unsigned WIDTH = 32;

  logic               clk;
  logic               reset_n;
  logic               op_start;
  logic               op_clear;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               op_done;

  int n_cmp;
  int n_err;

  mul_ctrl #(
    .WIDTH(WIDTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_start    (op_start),
    .op_clear    (op_clear),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .result      (result),
    .busy        (busy),
    .op_done     (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts an operation from a negedge; n counts edges after the sampling edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit poke_start, input string tag);
    logic [63:0] exp_prod;
    int          exp_lat;
    int          n;
    int          busy_cnt;
    exp_prod = 64'(a) * 64'(b);
    exp_lat  = WIDTH;
`ifdef MUL_ZERO_SKIP_EN
    if (a == 0 || b == 0) exp_lat = 0;
`endif
    multiplicand = a;
    multiplier   = b;
    op_start     = 1'b1;
    @(negedge clk);
    op_start     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    n        = 0;
    busy_cnt = 0;
    if (exp_lat > 0) chk({tag, " done low at start"}, 64'(op_done), 64'd0);
    while (op_done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (poke_start) op_start = (n == 5);
      @(negedge clk);
      n++;
    end
    op_start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, " result"}, result, exp_prod);
    repeat (3) @(negedge clk);
    chk({tag, " done held"}, 64'(op_done), 64'd1);
    chk({tag, " result held"}, result, exp_prod);
  endtask

  initial begin
    bit seen;
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("reset result", result, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(op_done), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 1'b0, "3x5");
    run_op(32'd7, 32'd9, 1'b0, "7x9 from done");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max sq");
    run_op(32'd3, 32'd5, 1'b1, "start in exec");
    run_op(32'h1234, 32'd0, 1'b0, "0x1234x0");
    run_op(32'd0, 32'hDEAD_BEEF, 1'b0, "0xb");
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) a = a & 32'h0000_FFFF;
      run_op(a, b, i[0], $sformatf("rand%0d", i));
    end

    // Clear+start in DONE: clear wins.
    op_start = 1'b1;
    op_clear = 1'b1;
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("clr in done busy", 64'(busy), 64'd0);
    chk("clr in done done", 64'(op_done), 64'd0);
    chk("clr in done result", result, 64'd0);

    // Abort mid-operation.
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    op_start     = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-abort busy", 64'(busy), 64'd1);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(op_done), 64'd0);
    chk("abort result", result, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (op_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("abort stays idle", 64'(seen), 64'd0);

    op_start = 1'b1;
    op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    chk("start+clr idle busy", 64'(busy), 64'd0);
    chk("start+clr idle done", 64'(op_done), 64'd0);

    // Asynchronous reset mid-operation.
    multiplicand = 32'd1234;
    multiplier   = 32'd5678;
    op_start     = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(op_done), 64'd0);
    chk("async rst result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (op_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("post rst idle", 64'(seen), 64'd0);

    run_op(32'd6, 32'd7, 1'b0, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port op_start  input  1  start request, one-cycle or level.
REQ-005 SHALL have port op_clear  input  1  synchronous abort/clear.
REQ-006 SHALL have port multiplicand  input  WIDTH  unsigned operand A.
REQ-007 SHALL have port multiplier  input  WIDTH  unsigned operand B.
REQ-008 SHALL have port result  output  2*WIDTH  product register.
REQ-009 SHALL have port busy  output  1  high while iterating.
REQ-010 SHALL have port op_done  output  1  high while the product is valid.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-012 IDLE: op_start=1 and op_clear=0 SHALL capture multiplicand into mcand_reg, load acc = {WIDTH zeros, multiplier}, clear count, go to EXEC.
REQ-013 EXEC, per edge: if acc[0]=1, acc SHALL become {carry, sum, acc[WIDTH-1:1]} with {carry, sum} = acc[2W-1:W] + mcand_reg, carry-in 0; else acc SHALL shift right by 1 with a zero MSB.
REQ-014 EXEC SHALL increment count each edge; the WIDTH-th iteration edge SHALL also set state to DONE.
REQ-015 op_done SHALL rise on the WIDTH-th rising edge after the edge that sampled op_start.
REQ-016 busy SHALL be 1 exactly in EXEC (WIDTH cycles).
REQ-017 result SHALL be driven by acc; its value is defined only while op_done=1.
REQ-018 The adder carry-out SHALL never be discarded; (2^W-1)^2 SHALL be exact.
REQ-019 Operand changes after capture SHALL have no effect on the running operation.
REQ-020 op_start in EXEC SHALL be ignored.
REQ-021 DONE SHALL hold result and op_done until op_start or op_clear.
REQ-022 op_start in DONE SHALL capture new operands and enter EXEC directly; op_done drops on that edge.
REQ-023 op_clear SHALL take priority over op_start in every state, forcing IDLE with acc = 0, op_done = 0, busy = 0.
REQ-024 op_clear in EXEC SHALL abort without ever asserting op_done.

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE and clear acc, mcand_reg, count, result, busy and op_done to 0.
REQ-026 Reset mid-EXEC SHALL abandon the operation; after release the block SHALL wait in IDLE for a new op_start.

Configuration
REQ-027 With MUL_ZERO_SKIP_EN defined: a start with multiplicand = 0 or multiplier = 0 SHALL go IDLE->DONE (or DONE->DONE) in one edge, with result 0, busy never asserted, and op_done high after one edge.
REQ-028 Without MUL_ZERO_SKIP_EN: every operation, including zero operands, SHALL take the full WIDTH iterations of REQ-015.

Structure
REQ-029 Package mul_pkg SHALL hold the state typedef mul_state_t (IDLE=2'b00, EXEC=2'b01, DONE=2'b10) and the count-width constant $clog2(WIDTH)+1.
REQ-030 The WIDTH-bit add SHALL be one instance of sub-module cla_add: carry-lookahead in 4-bit groups, group carries rippled, ports a, b, ci, sum, co.
REQ-031 The controller SHALL contain no other adder except the count increment.

Verification
REQ-032 3 x 5, WIDTH=32 -> result 0x0F; busy 32 cycles; op_done on the 32nd edge after start.
REQ-033 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE_00000001 (carry retention).
REQ-034 op_clear on EXEC iteration 10 -> IDLE next edge, result 0, op_done never asserted; op_start with op_clear in the same cycle -> stays IDLE.
REQ-035 In DONE with result 15, op_start with 7 x 9 -> op_done drops, EXEC again, result 63 after 32 edges.
REQ-036 0x1234 x 0 -> result 0: with MUL_ZERO_SKIP_EN op_done after 1 edge and busy never high; without it after 32 edges.
REQ-037 reset_n low at EXEC iteration 5, between clock edges -> all outputs 0 immediately; after release, state IDLE and no op_done.
